// File: rtl/banked_reg_file.sv
// ARM-style register file: per-mode banked r8-r14, SPSRs, exception entry/return.
// Two write ports (ALU, load), three read ports with optional same-cycle bypass.
module banked_reg_file #(
  parameter int                DATA_W     = 32,
  parameter int                PC_STEP    = 4,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] RESET_CPSR = DATA_W'(32'hD3),
  parameter bit                BYPASS     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rn_addr,
  input  logic [3:0]        rm_addr,
  input  logic [3:0]        rs_addr,
  output logic [DATA_W-1:0] rn_data,
  output logic [DATA_W-1:0] rm_data,
  output logic [7:0]        rs_data,
  input  logic              usr_view,
  input  logic              wa_en,
  input  logic [3:0]        wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pc_hold,
  output logic [DATA_W-1:0] pc_out,
  input  logic              flags_en,
  input  logic [3:0]        flags_in,
  input  logic              exc_en,
  input  logic [4:0]        exc_mode,
  input  logic [DATA_W-1:0] exc_lr,
  input  logic              spsr_restore,
  output logic [DATA_W-1:0] cpsr_out,
  output logic [DATA_W-1:0] spsr_out,
  output logic              mode_err
);

  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;

  localparam logic [4:0] P_PC  = 5'd31;
  localparam logic [2:0] S_NONE = 3'd7;

  // Physical slots: 0-14 USR, 15-21 FIQ r8-r14, 22-29 r13/r14 of IRQ,SVC,ABT,UND.
  function automatic logic [4:0] phys(
    input logic [3:0] a,
    input logic [4:0] m,
    input logic       u
  );
    logic [4:0] p;
    p = {1'b0, a};
    if (a == 4'd15) begin
      p = P_PC;
    end else if (!u) begin
      case (m)
        M_FIQ: if (a >= 4'd8)  p = {1'b0, a} + 5'd7;
        M_IRQ: if (a >= 4'd13) p = {1'b0, a} + 5'd9;
        M_SVC: if (a >= 4'd13) p = {1'b0, a} + 5'd11;
        M_ABT: if (a >= 4'd13) p = {1'b0, a} + 5'd13;
        M_UND: if (a >= 4'd13) p = {1'b0, a} + 5'd15;
        default: p = {1'b0, a};
      endcase
    end
    return p;
  endfunction

  function automatic logic [2:0] sidx(input logic [4:0] m);
    logic [2:0] s;
    case (m)
      M_FIQ:   s = 3'd0;
      M_IRQ:   s = 3'd1;
      M_SVC:   s = 3'd2;
      M_ABT:   s = 3'd3;
      M_UND:   s = 3'd4;
      default: s = S_NONE;
    endcase
    return s;
  endfunction

  logic [DATA_W-1:0] gpr  [30];
  logic [DATA_W-1:0] spsr [5];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] cpsr;
  logic [DATA_W-1:0] cpsr_fl;
  logic [DATA_W-1:0] cpsr_nx;
  logic              err_nx;

  logic [4:0] mode;
  logic [4:0] pa;
  logic [4:0] pb;
  logic [4:0] plr;
  logic [2:0] cur_s;
  logic [2:0] exc_s;
  logic       exc_ok;
  logic       byp_a;
  logic       byp_b;

  assign mode   = cpsr[4:0];
  assign pa     = phys(wa_addr, mode, usr_view);
  assign pb     = phys(wb_addr, mode, usr_view);
  assign plr    = phys(4'd14, exc_mode, 1'b0);
  assign cur_s  = sidx(mode);
  assign exc_s  = sidx(exc_mode);
  assign exc_ok = exc_en && (exc_s != S_NONE);
  assign byp_a  = BYPASS && wa_en && !rst;
  assign byp_b  = BYPASS && wb_en && !rst;

  logic [3:0]        raddr [3];
  logic [4:0]        rphys [3];
  logic [DATA_W-1:0] rval  [3];

  assign raddr[0] = rn_addr;
  assign raddr[1] = rm_addr;
  assign raddr[2] = rs_addr;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rphys[i] = phys(raddr[i], mode, usr_view);
      if (rphys[i] == P_PC) begin
        rval[i] = pc;
      end else begin
        rval[i] = gpr[rphys[i]];
        if (byp_a && pa == rphys[i]) rval[i] = wa_data;
        if (byp_b && pb == rphys[i]) rval[i] = wb_data;
      end
    end
  end

  assign rn_data  = rval[0];
  assign rm_data  = rval[1];
  assign rs_data  = rval[2][7:0];
  assign pc_out   = pc;
  assign cpsr_out = cpsr;
  assign spsr_out = (cur_s == S_NONE) ? '0 : spsr[cur_s];

  // Flags written alongside an entry belong to the interrupted context (SPSR).
  always_comb begin
    cpsr_fl = cpsr;
    if (flags_en) cpsr_fl[31:28] = flags_in;
  end

  always_comb begin
    cpsr_nx = cpsr;
    err_nx  = 1'b0;
    if (exc_en) begin
      if (exc_ok) begin
        cpsr_nx[4:0] = exc_mode;
        cpsr_nx[7]   = 1'b1;
        cpsr_nx[5]   = 1'b0;
        if (exc_mode == M_FIQ) cpsr_nx[6] = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end else if (spsr_restore) begin
      if (cur_s != S_NONE) cpsr_nx = spsr[cur_s];
      else                 err_nx  = 1'b1;
    end else if (flags_en) begin
      cpsr_nx[31:28] = flags_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 30; i++) gpr[i] <= '0;
      for (int i = 0; i < 5; i++)  spsr[i] <= '0;
      pc       <= RESET_PC;
      cpsr     <= RESET_CPSR;
      mode_err <= 1'b0;
    end else begin
      if (wa_en && pa != P_PC) gpr[pa] <= wa_data;
      if (wb_en && pb != P_PC) gpr[pb] <= wb_data;
      if (exc_ok) begin
        gpr[plr]    <= exc_lr;
        spsr[exc_s] <= cpsr_fl;
      end
      if (wb_en && pb == P_PC)      pc <= wb_data;
      else if (wa_en && pa == P_PC) pc <= wa_data;
      else if (!pc_hold)            pc <= pc + DATA_W'(PC_STEP);
      cpsr     <= cpsr_nx;
      mode_err <= err_nx;
    end
  end

endmodule
